noc_flit_rx: RTL and testbench
==============================

# noc_flit_rx

Credit-based NoC link receiver terminating one router-to-router output port (data/dest/is_tail/send in, credit back). Buffers incoming flits in a small FIFO, presents them on an AXI-Stream-style valid/ready interface, and returns one credit per flit drained. Used at mesh edges and in endpoint shims wherever a router output port must be consumed by non-router logic.

## Interface
- FLIT_WIDTH, 128, flit payload width
- DEST_WIDTH, 6, destination field width (TDEST + TID)
- BUFFER_DEPTH, 2, FIFO entries; equals credits the upstream sender starts with; legal values are 1 through 16
- clk_noc  in  1  NoC clock; the only clock
- rst_n  in  1  reset, asynchronous and active-low
- data_in  in  FLIT_WIDTH  flit payload from upstream router
- dest_in  in  DEST_WIDTH  flit destination
- is_tail_in  in  1  last flit of packet
- send_in  in  1  flit valid this cycle; no ready, guarded by credits
- credit_out  out  1  one-cycle pulse returns one credit upstream
- out_tvalid  out  1  head-of-FIFO flit valid
- out_tready  in  1  downstream accepts
- out_tdata  out  FLIT_WIDTH  head flit payload
- out_tdest  out  DEST_WIDTH  head flit destination
- out_tlast  out  1  head flit is_tail
- overflow_err  out  1  sticky: flit arrived with no free entry
- framing_err  out  1  sticky: packet framing violation (see Configuration)

## Operation
- Push: send_in=1 writes {data_in, dest_in, is_tail_in} at the rising edge when occupancy is below BUFFER_DEPTH, or when it equals BUFFER_DEPTH and a pop occurs in the same cycle.
- Push when full with no simultaneous pop: flit dropped, FIFO unchanged, overflow_err set and held until reset.
- Pop: out_tvalid && out_tready at an edge removes the head entry.
- Credit: each pop schedules exactly one credit_out pulse in the next cycle. One pop per cycle max, so pulses never merge. Credits returned plus occupancy plus in-flight credits always equals BUFFER_DEPTH.
- Simultaneous push and pop: occupancy unchanged; works at empty (bypass not allowed — pushed flit appears next cycle), full, and every level between.
- Read/write pointers wrap modulo BUFFER_DEPTH; occupancy counter width is clog2(BUFFER_DEPTH+1).
- Output fields are driven from the head entry. They are don't-care while out_tvalid=0.
- The packet tracker FSM has two states, IDLE and IN_PKT, and advances on accepted pushes only. IDLE -> IN_PKT on a non-tail flit. IN_PKT -> IDLE on a tail flit. A single-flit packet (tail in IDLE) stays in IDLE.

## Timing
- Reset (async assert, sync-safe deassert by upstream synchronizer) forces the following:
  - out_tvalid=0, credit_out=0, overflow_err=0, framing_err=0
  - FIFO empty, FSM in IDLE, pending credit cleared
- Latency send_in to out_tvalid: 1 cycle; flit pushed at edge N is visible after edge N.
- Latency pop to credit_out: 1 cycle; pop at edge N gives credit_out=1 between edges N and N+1.
- Reset mid-packet discards buffered flits and any pending credit. Upstream must be reset in the same domain so its counter returns to BUFFER_DEPTH.
- out_tvalid stays high, and head fields stay stable, until accepted (AXIS rules).
- Full throughput: one flit per cycle sustained when BUFFER_DEPTH>=2 and out_tready=1. With BUFFER_DEPTH=1, a round-trip credit loop limits throughput to one flit per 3 cycles at the sender.

## Configuration
- NOC_RX_PKT_CHECK_EN defined: framing checker enabled, operating in IN_PKT on accepted pushes only.
  - A dest_in differing from the packet's first-flit dest sets framing_err (sticky).
  - The flit is still buffered.
- NOC_RX_PKT_CHECK_EN undefined:
  - framing_err tied to 0.
  - Checker logic and first-flit dest register are not built.
  - The FSM still tracks packet state.

## Test plan
- Reset check: BUFFER_DEPTH=2, assert rst_n=0 with the FIFO holding 2 flits -> outputs immediately return to reset values; no credit_out pulse after release.
- Single flit: send_in with data 0xA5, dest 6'h09, tail=1, out_tready=1 -> out_tvalid one cycle later with those fields and tlast=1; credit_out pulses the cycle after the pop.
- Backpressure: out_tready=0, push 2 flits -> occupancy 2, no credits. Then raise out_tready -> 2 flits in order, 2 credit_out pulses on consecutive cycles.
- Overflow: FIFO full, out_tready=0, third send_in -> flit dropped, overflow_err=1, head unchanged. Then push with a same-cycle pop at full -> accepted, no error change.
- Streaming: 4-flit packet, out_tready=1, BUFFER_DEPTH=2 -> one flit per cycle, 4 credits total, tlast only on flit 4.
- Framing (macro defined): 3-flit packet with dest 9,9,5 -> framing_err=1 after flit 3; with the macro undefined, framing_err stays 0.

Source files
------------

// File: rtl/noc_flit_rx.sv
// Credit-based NoC link receiver: buffers flits, presents them as a valid/ready stream, returns one credit per drained flit.
// Optional packet framing checker is compiled in when NOC_RX_PKT_CHECK_EN is defined.
module noc_flit_rx #(
  parameter int FLIT_WIDTH   = 128,
  parameter int DEST_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [FLIT_WIDTH-1:0] out_tdata,
  output logic [DEST_WIDTH-1:0] out_tdest,
  output logic                  out_tlast,
  output logic                  overflow_err,
  output logic                  framing_err
);

  localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W   = $clog2(BUFFER_DEPTH + 1);
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  logic [ENTRY_W-1:0] r_mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_credit;
  logic               r_overflow_err;
  state_t             r_state;

  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;

  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = out_tvalid && out_tready;
  assign w_push = send_in && (!w_full || w_pop);
  assign w_drop = send_in && w_full && !w_pop;

  assign w_head       = r_mem[r_rd_ptr];
  assign out_tvalid   = (r_count != '0);
  assign out_tdata    = w_head[FLIT_WIDTH-1:0];
  assign out_tdest    = w_head[FLIT_WIDTH +: DEST_WIDTH];
  assign out_tlast    = w_head[ENTRY_W-1];
  assign credit_out   = r_credit;
  assign overflow_err = r_overflow_err;

  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {is_tail_in, dest_in, data_in};
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_credit       <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_credit <= w_pop;
      if (w_drop) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  // Packet tracker advances only on flits that were actually buffered.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (w_push) begin
      case (r_state)
        IDLE:    r_state <= is_tail_in ? IDLE : IN_PKT;
        IN_PKT:  r_state <= is_tail_in ? IDLE : IN_PKT;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef NOC_RX_PKT_CHECK_EN
  logic [DEST_WIDTH-1:0] r_first_dest;
  logic                  r_framing_err;

  // Every body/tail flit must carry the same destination as the head flit.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_first_dest  <= '0;
      r_framing_err <= 1'b0;
    end else if (w_push) begin
      if (r_state == IDLE) begin
        r_first_dest <= dest_in;
      end else if (dest_in != r_first_dest) begin
        r_framing_err <= 1'b1;
      end
    end
  end

  assign framing_err = r_framing_err;
`else
  assign framing_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_rx.sv
// Directed self-checking bench for noc_flit_rx at BUFFER_DEPTH=2.
// Framing expectations follow NOC_RX_PKT_CHECK_EN.
module tb_noc_flit_rx;

  logic         clk_noc;
  logic         rst_n;
  logic [127:0] data_in;
  logic [5:0]   dest_in;
  logic         is_tail_in;
  logic         send_in;
  logic         credit_out;
  logic         out_tvalid;
  logic         out_tready;
  logic [127:0] out_tdata;
  logic [5:0]   out_tdest;
  logic         out_tlast;
  logic         overflow_err;
  logic         framing_err;

  int total = 0;
  int bad   = 0;
  int creditCount;
  logic expFraming;

  noc_flit_rx #(
    .FLIT_WIDTH  (128),
    .DEST_WIDTH  (6),
    .BUFFER_DEPTH(2)
  ) dut (
    .clk_noc     (clk_noc),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .dest_in     (dest_in),
    .is_tail_in  (is_tail_in),
    .send_in     (send_in),
    .credit_out  (credit_out),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tdata   (out_tdata),
    .out_tdest   (out_tdest),
    .out_tlast   (out_tlast),
    .overflow_err(overflow_err),
    .framing_err (framing_err)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic applyStimulus(input logic send, input logic [127:0] data,
                               input logic [5:0] dest, input logic tail);
    send_in    = send;
    data_in    = data;
    dest_in    = dest;
    is_tail_in = tail;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef NOC_RX_PKT_CHECK_EN
    expFraming = 1'b1;
`else
    expFraming = 1'b0;
`endif
    rst_n      = 1'b0;
    out_tready = 1'b0;
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    #12;
    checkOutput("rst_tvalid", out_tvalid, 1'b0);
    checkOutput("rst_credit", credit_out, 1'b0);
    checkOutput("rst_ovf", overflow_err, 1'b0);
    checkOutput("rst_frm", framing_err, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single flit with immediate acceptance.
    out_tready = 1'b1;
    applyStimulus(1'b1, 128'hA5, 6'h09, 1'b1);
    tick();
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    checkOutput("single_tvalid", out_tvalid, 1'b1);
    checkOutput("single_tdata", out_tdata, 128'hA5);
    checkOutput("single_tdest", out_tdest, 6'h09);
    checkOutput("single_tlast", out_tlast, 1'b1);
    checkOutput("single_credit_early", credit_out, 1'b0);
    tick();
    checkOutput("single_tvalid_after_pop", out_tvalid, 1'b0);
    checkOutput("single_credit", credit_out, 1'b1);
    tick();
    checkOutput("single_credit_done", credit_out, 1'b0);

    // Backpressure: two flits held in the FIFO.
    out_tready = 1'b0;
    applyStimulus(1'b1, 128'h11, 6'h03, 1'b0);
    tick();
    applyStimulus(1'b1, 128'h22, 6'h03, 1'b1);
    tick();
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    checkOutput("bp_tvalid", out_tvalid, 1'b1);
    checkOutput("bp_head", out_tdata, 128'h11);
    checkOutput("bp_credit", credit_out, 1'b0);
    tick();
    checkOutput("bp_head_stable", out_tdata, 128'h11);
    checkOutput("bp_credit_none", credit_out, 1'b0);

    // Overflow at full, then push with simultaneous pop at full.
    applyStimulus(1'b1, 128'h33, 6'h03, 1'b1);
    tick();
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    checkOutput("ovf_flag", overflow_err, 1'b1);
    checkOutput("ovf_head", out_tdata, 128'h11);
    checkOutput("ovf_tlast", out_tlast, 1'b0);
    out_tready = 1'b1;
    applyStimulus(1'b1, 128'h44, 6'h03, 1'b1);
    tick();
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    checkOutput("fullpp_head", out_tdata, 128'h22);
    checkOutput("fullpp_tlast", out_tlast, 1'b1);
    checkOutput("fullpp_credit", credit_out, 1'b1);
    checkOutput("fullpp_ovf", overflow_err, 1'b1);
    tick();
    checkOutput("drain_head", out_tdata, 128'h44);
    checkOutput("drain_credit2", credit_out, 1'b1);
    tick();
    checkOutput("drain_empty", out_tvalid, 1'b0);
    checkOutput("drain_credit3", credit_out, 1'b1);
    tick();
    checkOutput("drain_credit_done", credit_out, 1'b0);

    // Reset asserted asynchronously with two flits buffered mid-packet.
    out_tready = 1'b0;
    applyStimulus(1'b1, 128'h55, 6'h07, 1'b0);
    tick();
    applyStimulus(1'b1, 128'h66, 6'h07, 1'b0);
    tick();
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    checkOutput("prerst_tvalid", out_tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_tvalid", out_tvalid, 1'b0);
    checkOutput("midrst_ovf", overflow_err, 1'b0);
    checkOutput("midrst_credit", credit_out, 1'b0);
    out_tready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("postrst_credit", credit_out, 1'b0);
    checkOutput("postrst_tvalid", out_tvalid, 1'b0);
    tick();
    checkOutput("postrst_credit2", credit_out, 1'b0);

    // Streaming a 4-flit packet at one flit per cycle.
    creditCount = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) applyStimulus(1'b1, 128'hB0 + 128'(i), 6'h0C, (i == 3));
      else       applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
      tick();
      if (credit_out) creditCount++;
      checkOutput($sformatf("stream_credit%0d", i), credit_out, (i > 0));
      checkOutput($sformatf("stream_tvalid%0d", i), out_tvalid, (i < 4));
      if (i < 4) begin
        checkOutput($sformatf("stream_data%0d", i), out_tdata, 128'hB0 + 128'(i));
        checkOutput($sformatf("stream_tlast%0d", i), out_tlast, (i == 3));
      end
    end
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    tick();
    if (credit_out) creditCount++;
    checkOutput("stream_credit_total", 128'(creditCount), 128'd4);

    // Framing: dest changes on the tail flit of a 3-flit packet.
    applyStimulus(1'b1, 128'hC0, 6'h09, 1'b0);
    tick();
    applyStimulus(1'b1, 128'hC1, 6'h09, 1'b0);
    tick();
    checkOutput("frm_clean", framing_err, 1'b0);
    applyStimulus(1'b1, 128'hC2, 6'h05, 1'b1);
    tick();
    applyStimulus(1'b0, 128'h0, 6'h0, 1'b0);
    checkOutput("frm_err", framing_err, expFraming);
    checkOutput("frm_buffered_dest", out_tdest, 6'h05);
    checkOutput("frm_buffered_data", out_tdata, 128'hC2);
    tick();
    checkOutput("frm_sticky", framing_err, expFraming);
    checkOutput("frm_drained", out_tvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
